// File: rtl/l1_tlb_param.sv
// l1_tlb_param: parametrised fully associative L1 TLB with ASID tags, selective flush and tree PLRU
module l1_tlb_param #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 20,
  parameter int ASID_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VPN_W-1:0]  req_vpn,
  input  logic              req_store,
  input  logic              req_fetch,
  input  logic              req_priv_s,
  input  logic              vm_enabled,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              status_sum,
  input  logic              status_mxr,
  output logic              resp_miss,
  output logic [PPN_W-1:0]  resp_ppn,
  output logic              resp_xcpt_ld,
  output logic              resp_xcpt_st,
  output logic              resp_xcpt_if,
  output logic              ptw_req_valid,
  input  logic              ptw_req_ready,
  output logic [VPN_W-1:0]  ptw_req_vpn,
  output logic              ptw_req_store,
  output logic              ptw_req_fetch,
  input  logic              ptw_resp_valid,
  input  logic [PPN_W-1:0]  ptw_resp_ppn,
  input  logic              ptw_resp_v,
  input  logic              ptw_resp_r,
  input  logic              ptw_resp_w,
  input  logic              ptw_resp_x,
  input  logic              ptw_resp_u,
  input  logic              ptw_resp_g,
  input  logic              ptw_resp_d,
  input  logic              flush_valid,
  input  logic              flush_use_asid,
  input  logic              flush_use_vpn,
  input  logic [ASID_W-1:0] flush_asid,
  input  logic [VPN_W-1:0]  flush_vpn
);
  localparam int IW = $clog2(ENTRIES);
  typedef enum logic [1:0] {S_READY, S_REQUEST, S_WAIT, S_WAIT_INV} state_t;
  state_t state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d, g_q, u_q, r_q, w_q, x_q, d_q, hit;
  logic [VPN_W-1:0] tag_vpn_q [ENTRIES];
  logic [ASID_W-1:0] tag_asid_q [ENTRIES];
  logic [PPN_W-1:0] ppn_q [ENTRIES];
  logic [ENTRIES-2:0] plru_q, plru_d;
  logic [VPN_W-1:0] vpn_q;
  logic store_q, fetch_q;
  logic [ASID_W-1:0] asid_q;
  logic [IW-1:0] victim_q, victim, hit_idx;
  logic [PPN_W-1:0] hit_ppn;
  logic any_hit, hu, hr, hw, hx, hd, user_ok, chk, refill, lookup_hit, take;

  // Point every tree node on the path to idx away from it.
  function automatic logic [ENTRIES-2:0] touch(input logic [ENTRIES-2:0] t, input logic [IW-1:0] idx);
    logic [ENTRIES-2:0] o;
    int n;
    o = t;
    n = 0;
    for (int l = IW - 1; l >= 0; l--) begin
      o[n] = !idx[l];
      n = 2 * n + 1 + int'(idx[l]);
    end
    return o;
  endfunction

  // Follow the tree bits from the root down to the least recently used leaf.
  function automatic logic [IW-1:0] plru_victim(input logic [ENTRIES-2:0] t);
    logic [IW-1:0] v;
    int n;
    v = '0;
    n = 0;
    for (int l = IW - 1; l >= 0; l--) begin
      v[l] = t[n];
      n = 2 * n + 1 + int'(t[n]);
    end
    return v;
  endfunction

  // Associative match, hit-entry fields and refill victim choice.
  always_comb begin
    hit = '0;
    hit_idx = '0;
    hit_ppn = '0;
    {hu, hr, hw, hx, hd} = '0;
    victim = plru_victim(plru_q);
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      hit[i] = valid_q[i] && tag_vpn_q[i] == req_vpn && (g_q[i] || tag_asid_q[i] == cur_asid);
      hit_idx = hit_idx | (hit[i] ? IW'(i) : '0);
      hit_ppn = hit_ppn | (ppn_q[i] & {PPN_W{hit[i]}});
      {hu, hr, hw, hx, hd} = {hu, hr, hw, hx, hd} | ({u_q[i], r_q[i], w_q[i], x_q[i], d_q[i]} & {5{hit[i]}});
      victim = valid_q[i] ? victim : IW'(i);
    end
    any_hit = |hit;
  end

  // Lookup response and permission checks.
  always_comb begin
    chk = vm_enabled && req_valid && any_hit && state_q == S_READY;
    user_ok = req_priv_s ? (!hu || status_sum) : hu;
    resp_miss = vm_enabled && req_valid && (!any_hit || state_q != S_READY);
    resp_ppn = vm_enabled ? hit_ppn : req_vpn[PPN_W-1:0];
    resp_xcpt_if = chk && req_fetch && (!user_ok || !hx);
    resp_xcpt_ld = chk && !req_fetch && !req_store && (!user_ok || !(hr || (status_mxr && hx)));
    resp_xcpt_st = chk && req_store && (!user_ok || !hw || !hd);
    req_ready = state_q == S_READY;
    ptw_req_valid = state_q == S_REQUEST;
    ptw_req_vpn = vpn_q;
    ptw_req_store = store_q;
    ptw_req_fetch = fetch_q;
  end

  // Refill FSM next state plus valid-bit and PLRU updates.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READY:   state_d = (req_valid && vm_enabled && !any_hit && !flush_valid) ? S_REQUEST : S_READY;
      S_REQUEST: state_d = ptw_req_ready ? (flush_valid ? S_WAIT_INV : S_WAIT) : (flush_valid ? S_READY : S_REQUEST);
      S_WAIT:    state_d = ptw_resp_valid ? S_READY : (flush_valid ? S_WAIT_INV : S_WAIT);
      default:   state_d = ptw_resp_valid ? S_READY : S_WAIT_INV;
    endcase
    take = state_q == S_READY && state_d == S_REQUEST;
    refill = state_q == S_WAIT && ptw_resp_valid && !flush_valid;
    lookup_hit = state_q == S_READY && req_valid && vm_enabled && any_hit;
    valid_d = valid_q;
    if (refill) valid_d[victim_q] = 1'b1;
    for (int i = 0; i < ENTRIES; i++)
      if (flush_valid && (!flush_use_vpn || tag_vpn_q[i] == flush_vpn) &&
          (!flush_use_asid || (!g_q[i] && tag_asid_q[i] == flush_asid))) valid_d[i] = 1'b0;
    plru_d = plru_q;
    if (lookup_hit) plru_d = touch(plru_q, hit_idx);
    if (refill) plru_d = touch(plru_q, victim_q);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_READY;
      valid_q <= '0;
      plru_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      plru_q <= plru_d;
    end
  end

  // Miss latch and entry payload; these need no reset.
  always_ff @(posedge clock) begin
    if (take) begin
      vpn_q <= req_vpn;
      store_q <= req_store;
      fetch_q <= req_fetch;
      asid_q <= cur_asid;
      victim_q <= victim;
    end
    if (refill) begin
      tag_vpn_q[victim_q] <= vpn_q;
      tag_asid_q[victim_q] <= asid_q;
      ppn_q[victim_q] <= ptw_resp_ppn;
      g_q[victim_q] <= ptw_resp_g;
      u_q[victim_q] <= ptw_resp_u;
      r_q[victim_q] <= ptw_resp_r && ptw_resp_v;
      w_q[victim_q] <= ptw_resp_w && ptw_resp_v;
      x_q[victim_q] <= ptw_resp_x && ptw_resp_v;
      d_q[victim_q] <= ptw_resp_d && ptw_resp_v;
    end
  end
endmodule

// File: tb/tb_l1_tlb_param.sv
// tb_l1_tlb_param: directed checks of lookup, refill, PLRU, flush and permissions
module tb_l1_tlb_param;
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_ready, req_store = 0, req_fetch = 0, req_priv_s = 1, vm_enabled = 1;
  logic [26:0] req_vpn = '0, ptw_req_vpn, flush_vpn = '0;
  logic [6:0] cur_asid = '0, flush_asid = '0;
  logic status_sum = 0, status_mxr = 0, resp_miss, resp_xcpt_ld, resp_xcpt_st, resp_xcpt_if;
  logic [19:0] resp_ppn, ptw_resp_ppn = '0;
  logic ptw_req_valid, ptw_req_ready = 0, ptw_req_store, ptw_req_fetch, ptw_resp_valid = 0;
  logic ptw_resp_v = 0, ptw_resp_r = 0, ptw_resp_w = 0, ptw_resp_x = 0, ptw_resp_u = 0, ptw_resp_g = 0, ptw_resp_d = 0;
  logic flush_valid = 0, flush_use_asid = 0, flush_use_vpn = 0;
  int total = 0, bad = 0;

  l1_tlb_param dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .req_store(req_store), .req_fetch(req_fetch), .req_priv_s(req_priv_s), .vm_enabled(vm_enabled),
    .cur_asid(cur_asid), .status_sum(status_sum), .status_mxr(status_mxr), .resp_miss(resp_miss),
    .resp_ppn(resp_ppn), .resp_xcpt_ld(resp_xcpt_ld), .resp_xcpt_st(resp_xcpt_st), .resp_xcpt_if(resp_xcpt_if),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_req_store(ptw_req_store), .ptw_req_fetch(ptw_req_fetch), .ptw_resp_valid(ptw_resp_valid),
    .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_v(ptw_resp_v), .ptw_resp_r(ptw_resp_r), .ptw_resp_w(ptw_resp_w),
    .ptw_resp_x(ptw_resp_x), .ptw_resp_u(ptw_resp_u), .ptw_resp_g(ptw_resp_g), .ptw_resp_d(ptw_resp_d),
    .flush_valid(flush_valid), .flush_use_asid(flush_use_asid), .flush_use_vpn(flush_use_vpn),
    .flush_asid(flush_asid), .flush_vpn(flush_vpn)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic look(input logic [26:0] vpn, input logic [6:0] asid, input logic st, input logic fe);
    req_valid = 1;
    req_vpn = vpn;
    cur_asid = asid;
    req_store = st;
    req_fetch = fe;
    #1;
  endtask

  // pte = {v, r, w, x, u, g, d}
  task automatic refill(input logic [26:0] vpn, input logic [6:0] asid, input logic [19:0] ppn, input logic [6:0] pte);
    look(vpn, asid, 0, 0);
    tick();
    req_valid = 0;
    ptw_req_ready = 1;
    tick();
    ptw_req_ready = 0;
    {ptw_resp_v, ptw_resp_r, ptw_resp_w, ptw_resp_x, ptw_resp_u, ptw_resp_g, ptw_resp_d} = pte;
    ptw_resp_ppn = ppn;
    ptw_resp_valid = 1;
    tick();
    ptw_resp_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (ptw_req_valid !== 1'b0) begin bad++; $display("FAIL reset_ptw_valid got=%b exp=0", ptw_req_valid); end
    look(27'h123, 7'd3, 0, 0);
    total++; if (resp_miss !== 1'b1) begin bad++; $display("FAIL reset_miss got=%b exp=1", resp_miss); end
    total++; if ({resp_xcpt_ld, resp_xcpt_st, resp_xcpt_if} !== 3'b000) begin bad++; $display("FAIL reset_xcpt got=%b exp=000", {resp_xcpt_ld, resp_xcpt_st, resp_xcpt_if}); end
  endtask

  task automatic test_basic_refill();
    tick();
    req_valid = 0;
    total++; if (ptw_req_valid !== 1'b1) begin bad++; $display("FAIL req_valid got=%b exp=1", ptw_req_valid); end
    total++; if (ptw_req_vpn !== 27'h123) begin bad++; $display("FAIL req_vpn got=%h exp=123", ptw_req_vpn); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL req_busy got=%b exp=0", req_ready); end
    ptw_req_ready = 1;
    tick();
    ptw_req_ready = 0;
    {ptw_resp_v, ptw_resp_r, ptw_resp_w, ptw_resp_x, ptw_resp_u, ptw_resp_g, ptw_resp_d} = 7'b1110001;
    ptw_resp_ppn = 20'hABCDE;
    ptw_resp_valid = 1;
    tick();
    ptw_resp_valid = 0;
    look(27'h123, 7'd3, 0, 0);
    total++; if (resp_miss !== 1'b0) begin bad++; $display("FAIL basic_hit got=%b exp=0", resp_miss); end
    total++; if (resp_ppn !== 20'hABCDE) begin bad++; $display("FAIL basic_ppn got=%h exp=abcde", resp_ppn); end
    total++; if ({resp_xcpt_ld, resp_xcpt_st, resp_xcpt_if} !== 3'b000) begin bad++; $display("FAIL basic_xcpt got=%b exp=000", {resp_xcpt_ld, resp_xcpt_st, resp_xcpt_if}); end
    look(27'h123, 7'd3, 1, 0);
    total++; if (resp_xcpt_st !== 1'b0) begin bad++; $display("FAIL basic_store got=%b exp=0", resp_xcpt_st); end
    req_valid = 0;
  endtask

  task automatic test_plru();
    int order [7] = '{6, 4, 5, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 8; i++) refill(27'h100 + 27'(i), 7'd1, 20'h1000 + 20'(i), 7'b1110001);
    foreach (order[k]) begin
      look(27'h100 + 27'(order[k]), 7'd1, 0, 0);
      total++; if (resp_ppn !== 20'h1000 + 20'(order[k])) begin bad++; $display("FAIL plru_fill%0d got=%h exp=%h", order[k], resp_ppn, 20'h1000 + 20'(order[k])); end
      tick();
      req_valid = 0;
    end
    refill(27'h200, 7'd1, 20'h22222, 7'b1110001);
    look(27'h200, 7'd1, 0, 0);
    total++; if ({resp_miss, resp_ppn} !== {1'b0, 20'h22222}) begin bad++; $display("FAIL plru_new got=%b/%h exp=0/22222", resp_miss, resp_ppn); end
    look(27'h107, 7'd1, 0, 0);
    total++; if (resp_miss !== 1'b1) begin bad++; $display("FAIL plru_evict7 got=%b exp=1", resp_miss); end
    look(27'h100, 7'd1, 0, 0);
    total++; if ({resp_miss, resp_ppn} !== {1'b0, 20'h01000}) begin bad++; $display("FAIL plru_keep0 got=%b/%h exp=0/01000", resp_miss, resp_ppn); end
    req_valid = 0;
  endtask

  task automatic test_asid_flush();
    do_reset();
    refill(27'h300, 7'd3, 20'h00300, 7'b1110001);
    refill(27'h301, 7'd3, 20'h00301, 7'b1110011);
    look(27'h300, 7'd4, 0, 0);
    total++; if (resp_miss !== 1'b1) begin bad++; $display("FAIL asid_other got=%b exp=1", resp_miss); end
    look(27'h301, 7'd4, 0, 0);
    total++; if ({resp_miss, resp_ppn} !== {1'b0, 20'h00301}) begin bad++; $display("FAIL asid_global got=%b/%h exp=0/00301", resp_miss, resp_ppn); end
    look(27'h300, 7'd3, 0, 0);
    flush_valid = 1; flush_use_asid = 1; flush_asid = 7'd3;
    #1;
    total++; if (resp_miss !== 1'b0) begin bad++; $display("FAIL flush_cycle got=%b exp=0", resp_miss); end
    tick();
    flush_valid = 0; flush_use_asid = 0;
    look(27'h300, 7'd3, 0, 0);
    total++; if (resp_miss !== 1'b1) begin bad++; $display("FAIL flush_asid got=%b exp=1", resp_miss); end
    req_valid = 0;
    look(27'h301, 7'd3, 0, 0);
    total++; if (resp_miss !== 1'b0) begin bad++; $display("FAIL flush_keepg got=%b exp=0", resp_miss); end
    req_valid = 0;
  endtask

  task automatic test_fault_entry();
    do_reset();
    refill(27'h400, 7'd2, 20'h00400, 7'b0111001);
    look(27'h400, 7'd2, 0, 0);
    total++; if ({resp_miss, resp_xcpt_ld} !== 2'b01) begin bad++; $display("FAIL fault_ld got=%b exp=01", {resp_miss, resp_xcpt_ld}); end
    tick();
    total++; if (ptw_req_valid !== 1'b0) begin bad++; $display("FAIL fault_nowalk got=%b exp=0", ptw_req_valid); end
    req_valid = 0;
  endtask

  task automatic test_flush_wait();
    do_reset();
    look(27'h500, 7'd1, 0, 0);
    tick();
    req_valid = 0;
    ptw_req_ready = 1;
    tick();
    ptw_req_ready = 0;
    flush_valid = 1;
    tick();
    flush_valid = 0;
    ptw_resp_ppn = 20'h55555;
    {ptw_resp_v, ptw_resp_r, ptw_resp_w, ptw_resp_x, ptw_resp_u, ptw_resp_g, ptw_resp_d} = 7'b1110001;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL inv_busy got=%b exp=0", req_ready); end
    ptw_resp_valid = 1;
    tick();
    ptw_resp_valid = 0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL inv_ready got=%b exp=1", req_ready); end
    look(27'h500, 7'd1, 0, 0);
    total++; if (resp_miss !== 1'b1) begin bad++; $display("FAIL inv_discard got=%b exp=1", resp_miss); end
    req_valid = 0;
  endtask

  task automatic test_permissions();
    do_reset();
    refill(27'h600, 7'd1, 20'h00600, 7'b1111101);
    refill(27'h601, 7'd1, 20'h00601, 7'b1110000);
    status_sum = 0;
    look(27'h600, 7'd1, 0, 0);
    total++; if (resp_xcpt_ld !== 1'b1) begin bad++; $display("FAIL perm_nosum got=%b exp=1", resp_xcpt_ld); end
    status_sum = 1;
    #1;
    total++; if (resp_xcpt_ld !== 1'b0) begin bad++; $display("FAIL perm_sum got=%b exp=0", resp_xcpt_ld); end
    status_sum = 0;
    look(27'h601, 7'd1, 1, 0);
    total++; if (resp_xcpt_st !== 1'b1) begin bad++; $display("FAIL perm_dirty got=%b exp=1", resp_xcpt_st); end
    look(27'h601, 7'd1, 0, 1);
    total++; if (resp_xcpt_if !== 1'b1) begin bad++; $display("FAIL perm_nox got=%b exp=1", resp_xcpt_if); end
    req_valid = 0;
  endtask

  task automatic test_passthrough();
    vm_enabled = 0;
    look(27'h45678, 7'd1, 0, 0);
    total++; if ({resp_miss, resp_ppn} !== {1'b0, 20'h45678}) begin bad++; $display("FAIL pass got=%b/%h exp=0/45678", resp_miss, resp_ppn); end
    tick();
    total++; if (ptw_req_valid !== 1'b0) begin bad++; $display("FAIL pass_nowalk got=%b exp=0", ptw_req_valid); end
    req_valid = 0;
    vm_enabled = 1;
  endtask

  task automatic test_reset_midwalk();
    look(27'h700, 7'd1, 0, 0);
    tick();
    req_valid = 0;
    ptw_req_ready = 1;
    tick();
    ptw_req_ready = 0;
    do_reset();
    total++; if ({req_ready, ptw_req_valid} !== 2'b10) begin bad++; $display("FAIL midwalk_reset got=%b exp=10", {req_ready, ptw_req_valid}); end
    ptw_resp_valid = 1;
    tick();
    ptw_resp_valid = 0;
    look(27'h700, 7'd1, 0, 0);
    total++; if (resp_miss !== 1'b1) begin bad++; $display("FAIL midwalk_ignored got=%b exp=1", resp_miss); end
    req_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic_refill();
    test_plru();
    test_asid_flush();
    test_fault_entry();
    test_flush_wait();
    test_permissions();
    test_passthrough();
    test_reset_midwalk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_tlb_param.md
Name: l1_tlb_param

Overview:
- Parametrised, fully associative L1 TLB; successor of the fixed 8-entry L1 TLB.
- Sits between a core memory port (fetch or load/store) and the shared L2 TLB / page-table walker.
- Adds over the previous generation: configurable depth and widths, ASID-tagged entries with a global bit, selective flush (all / by ASID / by VPN / both), tree pseudo-LRU for any power-of-two depth, and cached page-fault entries.
- Lookup is combinational; refill uses a single-outstanding request/response handshake.

Parameters:
- ENTRIES, 8, number of entries; power of two, 2..64.
- VPN_W, 27, virtual page number width.
- PPN_W, 20, physical page number width; PPN_W <= VPN_W.
- ASID_W, 7, address-space ID width.

Ports:
- clock  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  1  lookup request.
- req_ready  out  1  high only in S_READY.
- req_vpn  in  VPN_W  lookup VPN.
- req_store  in  1  access is a store.
- req_fetch  in  1  access is an instruction fetch.
- req_priv_s  in  1  effective privilege is supervisor (0 = user).
- vm_enabled  in  1  translation on; 0 = passthrough.
- cur_asid  in  ASID_W  current ASID.
- status_sum  in  1  supervisor may access user pages.
- status_mxr  in  1  executable pages are readable.
- resp_miss  out  1  translation not available this cycle.
- resp_ppn  out  PPN_W  translated PPN.
- resp_xcpt_ld, resp_xcpt_st, resp_xcpt_if  out  1 each  permission faults.
- ptw_req_valid  out  1  refill request.
- ptw_req_ready  in  1  walker accepts request.
- ptw_req_vpn  out  VPN_W  latched miss VPN.
- ptw_req_store, ptw_req_fetch  out  1 each  latched access type.
- ptw_resp_valid  in  1  walk result; one-cycle pulse.
- ptw_resp_ppn  in  PPN_W  PTE PPN.
- ptw_resp_v, ptw_resp_r, ptw_resp_w, ptw_resp_x, ptw_resp_u, ptw_resp_g, ptw_resp_d  in  1 each  PTE bits.
- flush_valid  in  1  flush request; one-cycle pulse.
- flush_use_asid  in  1  restrict flush to flush_asid.
- flush_use_vpn  in  1  restrict flush to flush_vpn.
- flush_asid  in  ASID_W  ASID to flush.
- flush_vpn  in  VPN_W  VPN to flush.

Behaviour:
- Reset: state=S_READY, all valid bits 0, PLRU bits 0. Tags, PPNs and permissions are not reset.
- Outputs after reset:
  - req_ready=1, ptw_req_valid=0.
  - resp_miss = vm_enabled & req_valid.
  - xcpt outputs 0.
- Hit on entry i: valid[i] & tag_vpn[i]==req_vpn & (g[i] | tag_asid[i]==cur_asid).
  - Hits are one-hot by construction; resp_ppn is the OR of the hitting entries' PPNs.
- Passthrough (vm_enabled=0):
  - resp_miss=0, resp_ppn=req_vpn[PPN_W-1:0], all xcpt 0.
  - No PTW traffic, no PLRU update.
- Translated mode:
  - resp_miss = req_valid & (!hit | state!=S_READY).
  - xcpt outputs are 0 whenever resp_miss=1.
- Permission check on hit:
  - user_ok = req_priv_s ? (!u | status_sum) : u.
  - resp_xcpt_if = req_fetch & (!user_ok | !x).
  - resp_xcpt_ld = !req_fetch & !req_store & (!user_ok | !(r | (status_mxr & x))).
  - resp_xcpt_st = req_store & (!user_ok | !w | !d).
- State machine:
  - S_READY -> S_REQUEST when req_valid & vm_enabled & !hit & !flush_valid. Same cycle: latch req_vpn, req_store, req_fetch, cur_asid and the victim index.
  - S_REQUEST: ptw_req_valid=1.
    - ptw_req_ready & flush_valid -> S_WAIT_INV.
    - ptw_req_ready & !flush_valid -> S_WAIT.
    - !ptw_req_ready & flush_valid -> S_READY (request withdrawn).
  - S_WAIT:
    - ptw_resp_valid & !flush_valid -> refill the victim entry, then S_READY.
    - ptw_resp_valid & flush_valid -> discard the result, apply the flush, then S_READY.
    - flush_valid only -> S_WAIT_INV.
  - S_WAIT_INV: ptw_resp_valid -> S_READY with the result discarded; no entry is written.
- Victim selection: lowest-index invalid entry; if none is invalid, the tree-PLRU victim.
- Refill writes the latched VPN and ASID, ptw_resp_ppn, g and u.
  - r/w/x/d are written as the PTE bits ANDed with ptw_resp_v.
  - A non-valid PTE is therefore cached as a fault entry, so the retried access hits and raises an exception. Walks are not repeated.
- PLRU: ENTRIES-1 tree bits; each touch points the path away from the touched entry.
  - Touch on a lookup hit in S_READY (req_valid, vm_enabled).
  - Touch on the refilled entry.
  - If both happen in the same cycle, the refill touch wins.
- Flush (valid bits only, effective the next cycle; accepted in any state):
  - none set: clear all entries.
  - use_asid only: clear entries with !g & asid match.
  - use_vpn only: clear entries with VPN match.
  - both set: clear entries with VPN match & !g & asid match.
  - A lookup in the flush cycle still sees the pre-flush contents.
- Reset mid-walk returns to S_READY; a later ptw_resp_valid in S_READY is ignored.

Test Plan:
- Reset, vm_enabled=1, req_vpn=0x123, cur_asid=3 -> resp_miss=1, then ptw_req_valid=1 with ptw_req_vpn=0x123. Respond ppn=0xABCDE, v=r=w=d=1 -> the next lookup of 0x123 hits, resp_ppn=0xABCDE, no xcpt.
- Fill 8 distinct VPNs, then re-touch entries 0..6; a ninth miss -> refill lands in entry 7.
- Entry with g=0 and ASID 3; lookup with cur_asid=4 -> miss. An entry with g=1 hits under any ASID. Flush with use_asid=1, asid=3 -> the g=0 entry misses, the g=1 entry still hits.
- PTE with v=0 -> retried access hits with resp_miss=0 and resp_xcpt_ld=1, and no second ptw_req_valid.
- flush_valid in S_WAIT, then ptw_resp_valid -> no entry written, state S_READY, the same VPN misses again.
- User page (u=1) with req_priv_s=1, status_sum=0, load -> resp_xcpt_ld=1. Store to a page with d=0 -> resp_xcpt_st=1. vm_enabled=0, req_vpn=0x4_5678 -> resp_ppn=0x45678, resp_miss=0.
